uart_rx_mem_writer: RTL and testbench

//  Receive side of the memory-mapped UART link: samples the serial line, recovers 8N1

---
 rtl/uart_rx_mem_writer.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_mem_writer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mem_writer.sv
// rtl/uart_rx_mem_writer.sv - 8N1 UART receiver that writes good bytes into a circular byte memory
// Optional UART_RX_PARITY_EN selects 8E1 framing with a PARITY state ahead of STOP.
module uart_rx_mem_writer #(
  parameter int DIV        = 27,
  parameter int OVERSAMPLE = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [7:0]        data_recorded,
  output logic              rx_valid,
  output logic              frame_err,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   byte_count,
  output logic              overrun,
  input  logic              ovr_clr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
  localparam logic [OW-1:0]   OS_LAST  = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0]   OS_MID   = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [ADDR_W:0] FULL     = (ADDR_W + 1)'(DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK, PARITY} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t state_q, state_d;

  logic          sync1, sync2, ls_d;
  logic          ls;
  logic [DW-1:0] div_cnt;
  logic [OW-1:0] os_cnt;
  logic          tick, mid, start_det;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          shift_en, good, bad;
  logic [7:0]    mem [DEPTH];

  // ls_d holds the previous synchronised sample for start-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      ls_d  <= 1'b1;
    end else begin
      sync1 <= line;
      sync2 <= sync1;
      ls_d  <= sync2;
    end
  end

  assign ls        = sync2;
  assign start_det = (state_q == IDLE) && ls_d && !ls;
  assign tick      = (div_cnt == DIV_LAST);
  assign mid       = tick && (os_cnt == OS_MID);

  always_ff @(posedge clk) begin
    if (rst || start_det) begin
      div_cnt <= '0;
      os_cnt  <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_det) state_d = START;
      START: if (mid) state_d = ls ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (mid && bit_idx == 3'd7) state_d = PARITY;
      PARITY: if (mid) state_d = STOP;
`else
      DATA:   if (mid && bit_idx == 3'd7) state_d = STOP;
`endif
      STOP:  if (mid) state_d = ls ? IDLE : BREAK;
      BREAK: if (ls) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_en, par_err;

  always_comb begin
    shift_en = (state_q == DATA) && mid;
    par_en   = (state_q == PARITY) && mid;
    good     = (state_q == STOP) && mid && ls && !par_err;
    bad      = (state_q == STOP) && mid && (!ls || par_err);
  end

  // Even parity: data bits plus parity bit must XOR to zero
  always_ff @(posedge clk) begin
    if (rst || start_det) par_err <= 1'b0;
    else if (par_en)      par_err <= ^{shift, ls};
  end
`else
  always_comb begin
    shift_en = (state_q == DATA) && mid;
    good     = (state_q == STOP) && mid && ls;
    bad      = (state_q == STOP) && mid && !ls;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst || start_det) begin
      bit_idx <= '0;
      shift   <= '0;
    end else if (shift_en) begin
      bit_idx <= bit_idx + 1'b1;
      shift   <= {ls, shift[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid      <= 1'b0;
      frame_err     <= 1'b0;
      data_recorded <= '0;
      wr_addr       <= '0;
      byte_count    <= '0;
      overrun       <= 1'b0;
    end else begin
      rx_valid  <= good;
      frame_err <= bad;
      if (good) begin
        data_recorded <= shift;
        wr_addr       <= wr_addr + 1'b1;
        if (byte_count != FULL) byte_count <= byte_count + 1'b1;
      end
      // A write into a full buffer outranks a simultaneous clear
      if (good && byte_count == FULL) overrun <= 1'b1;
      else if (ovr_clr)               overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (good) mem[wr_addr] <= shift;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_uart_rx_mem_writer.sv
// tb/tb_uart_rx_mem_writer.sv - directed bench for uart_rx_mem_writer (DIV=4, bit = 64 clk)
module tb_uart_rx_mem_writer;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       line = 1'b1;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic [7:0] data_recorded;
  logic       rx_valid;
  logic       frame_err;
  logic [3:0] wr_addr;
  logic [4:0] byte_count;
  logic       overrun;
  logic       ovr_clr = 1'b0;

  int checks = 0;
  int failures = 0;
  int rv_cnt = 0;
  int fe_cnt = 0;
  int rv0, fe0;
  logic [7:0] rd_val;

  uart_rx_mem_writer #(.DIV(4), .OVERSAMPLE(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .line(line), .rd_addr(rd_addr), .rd_data(rd_data),
    .data_recorded(data_recorded), .rx_valid(rx_valid), .frame_err(frame_err),
    .wr_addr(wr_addr), .byte_count(byte_count), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) rv_cnt++;
    if (frame_err) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    line = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    line = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    line = ^b;
    repeat (BIT) @(negedge clk);
`endif
    line = stop_bit;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic read_mem(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  initial begin
    // Reset state, sampled while rst is held
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_data_recorded", data_recorded, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_wr_addr", wr_addr, 4'd0);
    check("rst_byte_count", byte_count, 5'd0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: single good byte
    rv0 = rv_cnt; fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    check("t1_rx_pulses", rv_cnt - rv0, 1);
    check("t1_frame_err", fe_cnt - fe0, 0);
    check("t1_data_recorded", data_recorded, 8'hA5);
    check("t1_wr_addr", wr_addr, 4'd1);
    check("t1_byte_count", byte_count, 5'd1);
    read_mem(4'd0, rd_val);
    check("t1_mem0", rd_val, 8'hA5);

    // 2: short glitch is rejected, next frame still decodes
    do_reset();
    rv0 = rv_cnt; fe0 = fe_cnt;
    line = 1'b0;
    repeat (20) @(negedge clk);
    line = 1'b1;
    repeat (200) @(negedge clk);
    check("t2_rx_pulses", rv_cnt - rv0, 0);
    check("t2_frame_err", fe_cnt - fe0, 0);
    check("t2_wr_addr", wr_addr, 4'd0);
    check("t2_byte_count", byte_count, 5'd0);
    send_frame(8'h42, 1'b1);
    repeat (20) @(negedge clk);
    check("t2_after_glitch_byte", data_recorded, 8'h42);

    // 3: bad stop bit, line held in break, then a good byte
    do_reset();
    rv0 = rv_cnt; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (200) @(negedge clk);
    line = 1'b1;
    repeat (BIT) @(negedge clk);
    send_frame(8'h11, 1'b1);
    repeat (20) @(negedge clk);
    check("t3_frame_err", fe_cnt - fe0, 1);
    check("t3_rx_pulses", rv_cnt - rv0, 1);
    check("t3_wr_addr", wr_addr, 4'd1);
    check("t3_byte_count", byte_count, 5'd1);
    read_mem(4'd0, rd_val);
    check("t3_mem0", rd_val, 8'h11);

    // 4: 17 back-to-back bytes wrap the buffer and set overrun
    do_reset();
    rv0 = rv_cnt;
    for (int k = 1; k <= 17; k++) send_frame(8'(k), 1'b1);
    repeat (20) @(negedge clk);
    check("t4_rx_pulses", rv_cnt - rv0, 17);
    check("t4_wr_addr", wr_addr, 4'd1);
    check("t4_byte_count", byte_count, 5'd16);
    check("t4_overrun", overrun, 1'b1);
    check("t4_data_recorded", data_recorded, 8'h11);
    read_mem(4'd0, rd_val);
    check("t4_mem0", rd_val, 8'h11);
    read_mem(4'd1, rd_val);
    check("t4_mem1", rd_val, 8'h02);
    read_mem(4'd15, rd_val);
    check("t4_mem15", rd_val, 8'h10);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("t4_ovr_clr", overrun, 1'b0);
    @(negedge clk);
    check("t4_ovr_stays_clear", overrun, 1'b0);

    // 5: reset during bit 4 of 0x5A discards the partial byte
    do_reset();
    rv0 = rv_cnt; fe0 = fe_cnt;
    line = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      line = ((8'h5A >> i) & 8'h01) != 0;
      repeat (BIT) @(negedge clk);
    end
    line = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("t5_no_pulse_partial", rv_cnt - rv0, 0);
    send_frame(8'h77, 1'b1);
    repeat (20) @(negedge clk);
    check("t5_rx_pulses", rv_cnt - rv0, 1);
    check("t5_frame_err", fe_cnt - fe0, 0);
    check("t5_wr_addr", wr_addr, 4'd1);
    check("t5_data_recorded", data_recorded, 8'h77);
    read_mem(4'd0, rd_val);
    check("t5_mem0", rd_val, 8'h77);

`ifdef UART_RX_PARITY_EN
    // 6: good parity is written, flipped parity is a frame error with no write
    do_reset();
    rv0 = rv_cnt; fe0 = fe_cnt;
    send_frame(8'h03, 1'b1);
    repeat (20) @(negedge clk);
    check("t6_good_rx", rv_cnt - rv0, 1);
    check("t6_good_wr_addr", wr_addr, 4'd1);
    line = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line = ((8'h03 >> i) & 8'h01) != 0;
      repeat (BIT) @(negedge clk);
    end
    line = 1'b1;
    repeat (BIT) @(negedge clk);
    repeat (BIT) @(negedge clk);
    repeat (20) @(negedge clk);
    check("t6_bad_frame_err", fe_cnt - fe0, 1);
    check("t6_bad_rx", rv_cnt - rv0, 1);
    check("t6_bad_wr_addr", wr_addr, 4'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
